output_layer_collector: RTL and testbench

//  Consumer end of the output-layer result interface. Captures the two signed

---
 rtl/output_layer_collector.sv | 131 +++++++++++++
 tb/tb_output_layer_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_layer_collector.sv
// Pairs the two output-layer neuron scores, decides the class by argmax and
// presents class/margin to the host over a valid/ack handshake.
module output_layer_collector #(
  parameter int DATA_W  = 17,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in0,
  input  logic                     in0_ready,
  input  logic signed [DATA_W-1:0] in1,
  input  logic                     in1_ready,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic                     class_id,
  output logic [DATA_W:0]          margin,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic                     timeout_err,
  output logic                     overrun,
  input  logic                     err_clr
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, PARTIAL, DECIDE, HOLD} state_t;

  state_t                    state, state_nx;
  logic signed [DATA_W-1:0]  score0, score1;
  logic                      have0, have1;
  logic [TW-1:0]             timer, timer_nx;
  logic                      load0, load1, clr_have, set_ovr, set_to, decide, ack_take;
  logic                      miss, dup;
  logic signed [DATA_W:0]    diff_p0;

  // Sign-extend both operands by one bit so the difference never overflows.
  function automatic logic signed [DATA_W:0] diff_ext(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    return $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
  endfunction

  function automatic logic [DATA_W:0] abs_mag(input logic signed [DATA_W:0] d);
    return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  assign diff_p0      = diff_ext(score0, score1);
  assign result_valid = (state == HOLD);
  assign miss         = have0 ? in1_ready : in0_ready;
  assign dup          = have0 ? in0_ready : in1_ready;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    load0    = 1'b0;
    load1    = 1'b0;
    clr_have = 1'b0;
    set_ovr  = 1'b0;
    set_to   = 1'b0;
    decide   = 1'b0;
    ack_take = 1'b0;
    case (state)
      IDLE, HOLD: begin
        // A HOLD cycle with ack behaves exactly like IDLE for new pulses.
        if (state == IDLE || result_ack) begin
          ack_take = (state == HOLD);
          load0    = in0_ready;
          load1    = in1_ready;
          timer_nx = '0;
          if (in0_ready && in1_ready)      state_nx = DECIDE;
          else if (in0_ready || in1_ready) state_nx = PARTIAL;
          else                             state_nx = IDLE;
        end else begin
          set_ovr = in0_ready | in1_ready;
        end
      end
      PARTIAL: begin
        load0   = in0_ready;
        load1   = in1_ready;
        set_ovr = dup;
        if (miss) begin
          state_nx = DECIDE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          set_to   = 1'b1;
          clr_have = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DECIDE: begin
        set_ovr  = in0_ready | in1_ready;
        decide   = 1'b1;
        clr_have = 1'b1;
        state_nx = HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      have0       <= 1'b0;
      have1       <= 1'b0;
      score0      <= '0;
      score1      <= '0;
      class_id    <= 1'b0;
      margin      <= '0;
      sample_cnt  <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      have0 <= clr_have ? 1'b0 : (have0 | load0);
      have1 <= clr_have ? 1'b0 : (have1 | load1);
      if (load0) score0 <= in0;
      if (load1) score1 <= in1;
      // Decision stage: register argmax and margin from the held pair.
      if (decide) begin
        class_id <= diff_p0[DATA_W];
        margin   <= abs_mag(diff_p0);
      end
      sample_cnt  <= sample_cnt + CNT_W'(ack_take);
      timeout_err <= set_to  | (timeout_err & ~err_clr);
      overrun     <= set_ovr | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_output_layer_collector.sv
// Bench for output_layer_collector: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_output_layer_collector;

  localparam int DATA_W  = 17;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic signed [DATA_W-1:0] in0 = '0, in1 = '0;
  logic                     in0_ready = 1'b0, in1_ready = 1'b0;
  logic                     result_ack = 1'b0, err_clr = 1'b0;
  logic                     result_valid, class_id, timeout_err, overrun;
  logic [DATA_W:0]          margin;
  logic [CNT_W-1:0]         sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  output_layer_collector #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in0_ready(in0_ready), .in1(in1), .in1_ready(in1_ready),
    .result_valid(result_valid), .result_ack(result_ack),
    .class_id(class_id), .margin(margin), .sample_cnt(sample_cnt),
    .timeout_err(timeout_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a pairing slot, an outbox (empty / computing / presenting)
  // and sticky flags, all in plain integers.
  bit m_got[2];
  int m_sc[2];
  int m_wait;
  int m_phase;
  int m_pair0, m_pair1;
  bit m_cls;
  int m_margin, m_cnt;
  bit m_to, m_ovr;

  function automatic void model_update(bit p0, bit p1, int v0, int v1, bit ack, bit clr, bit r);
    bit e_ovr, e_to;
    bit pulse[2];
    int v[2];
    int h, ms, d;
    if (r) begin
      m_got = '{0, 0}; m_sc = '{0, 0}; m_wait = 0; m_phase = 0;
      m_cls = 0; m_margin = 0; m_cnt = 0; m_to = 0; m_ovr = 0;
      return;
    end
    e_ovr = 0; e_to = 0;
    pulse = '{p0, p1};
    v = '{v0, v1};
    if (m_phase == 1) begin
      if (p0 || p1) e_ovr = 1;
      m_phase  = 2;
      m_cls    = (m_pair1 > m_pair0);
      d        = m_pair0 - m_pair1;
      m_margin = (d < 0) ? -d : d;
    end else if (m_phase == 2 && !ack) begin
      if (p0 || p1) e_ovr = 1;
    end else begin
      if (m_phase == 2) begin
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_phase = 0;
      end
      if (!m_got[0] && !m_got[1]) begin
        for (int i = 0; i < 2; i++)
          if (pulse[i]) begin m_got[i] = 1; m_sc[i] = v[i]; end
        m_wait = 0;
      end else begin
        h  = m_got[0] ? 0 : 1;
        ms = 1 - h;
        if (pulse[h]) begin m_sc[h] = v[h]; e_ovr = 1; end
        if (pulse[ms]) begin
          m_sc[ms] = v[ms]; m_got[ms] = 1;
        end else if (m_wait == TIMEOUT - 1) begin
          m_got = '{0, 0}; e_to = 1;
        end else begin
          m_wait++;
        end
      end
      if (m_got[0] && m_got[1]) begin
        m_pair0 = m_sc[0]; m_pair1 = m_sc[1];
        m_got = '{0, 0};
        m_phase = 1;
      end
    end
    m_to  = e_to  | (m_to  & !clr);
    m_ovr = e_ovr | (m_ovr & !clr);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit p0, input bit p1, input int v0, input int v1,
                      input bit ack, input bit clr, input bit r);
    in0_ready = p0; in1_ready = p1;
    in0 = v0[DATA_W-1:0]; in1 = v1[DATA_W-1:0];
    result_ack = ack; err_clr = clr; rst = r;
    @(posedge clk);
    model_update(p0, p1, v0, v1, ack, clr, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},   int'(result_valid), int'(m_phase == 2));
    check({tag, ".class"},   int'(class_id),     int'(m_cls));
    check({tag, ".margin"},  int'(margin),       m_margin);
    check({tag, ".cnt"},     int'(sample_cnt),   m_cnt);
    check({tag, ".timeout"}, int'(timeout_err),  int'(m_to));
    check({tag, ".overrun"}, int'(overrun),      int'(m_ovr));
  endtask

  typedef struct {
    bit p0, p1; int v0, v1; bit ack, clr, r;
    bit e_vld, e_cls; int e_mar, e_cnt; bit e_to, e_ovr;
  } vec_t;

  function automatic vec_t mk(bit p0, bit p1, int v0, int v1, bit ack, bit clr, bit r,
                              bit vld, bit cls, int mar, int cnt, bit to, bit ovr);
    vec_t t;
    t.p0 = p0; t.p1 = p1; t.v0 = v0; t.v1 = v1; t.ack = ack; t.clr = clr; t.r = r;
    t.e_vld = vld; t.e_cls = cls; t.e_mar = mar; t.e_cnt = cnt; t.e_to = to; t.e_ovr = ovr;
    return t;
  endfunction

  vec_t tbl[19];
  bit   seen_valid;

  initial begin
    tbl[0]  = mk(0, 0,     0,      0, 0, 0, 1,  0, 0,      0, 0, 0, 0);
    tbl[1]  = mk(1, 1,   100,    -50, 0, 0, 0,  0, 0,      0, 0, 0, 0);
    tbl[2]  = mk(0, 0,     0,      0, 0, 0, 0,  1, 0,    150, 0, 0, 0);
    tbl[3]  = mk(0, 0,     0,      0, 1, 0, 0,  0, 0,    150, 1, 0, 0);
    tbl[4]  = mk(0, 1,     0, -65536, 0, 0, 0,  0, 0,    150, 1, 0, 0);
    tbl[5]  = mk(0, 0,     0,      0, 0, 0, 0,  0, 0,    150, 1, 0, 0);
    tbl[6]  = mk(0, 0,     0,      0, 0, 0, 0,  0, 0,    150, 1, 0, 0);
    tbl[7]  = mk(1, 0, 65535,      0, 0, 0, 0,  0, 0,    150, 1, 0, 0);
    tbl[8]  = mk(0, 0,     0,      0, 0, 0, 0,  1, 0, 131071, 1, 0, 0);
    tbl[9]  = mk(0, 0,     0,      0, 1, 0, 0,  0, 0, 131071, 2, 0, 0);
    tbl[10] = mk(1, 1,     7,      7, 0, 0, 0,  0, 0, 131071, 2, 0, 0);
    tbl[11] = mk(0, 0,     0,      0, 0, 0, 0,  1, 0,      0, 2, 0, 0);
    tbl[12] = mk(0, 0,     0,      0, 1, 0, 0,  0, 0,      0, 3, 0, 0);
    tbl[13] = mk(1, 0,     5,      0, 0, 0, 0,  0, 0,      0, 3, 0, 0);
    tbl[14] = mk(1, 0,     9,      0, 0, 0, 0,  0, 0,      0, 3, 0, 1);
    tbl[15] = mk(0, 1,     0,      3, 0, 0, 0,  0, 0,      0, 3, 0, 1);
    tbl[16] = mk(0, 0,     0,      0, 0, 0, 0,  1, 0,      6, 3, 0, 1);
    tbl[17] = mk(0, 0,     0,      0, 1, 0, 0,  0, 0,      6, 4, 0, 1);
    tbl[18] = mk(0, 0,     0,      0, 0, 1, 0,  0, 0,      6, 4, 0, 0);

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Vector table: pairing, split extremes, tie, duplicate and flag clear.
    foreach (tbl[i]) begin
      step(tbl[i].p0, tbl[i].p1, tbl[i].v0, tbl[i].v1, tbl[i].ack, tbl[i].clr, tbl[i].r);
      check($sformatf("vec%0d.valid", i),   int'(result_valid), int'(tbl[i].e_vld));
      check($sformatf("vec%0d.class", i),   int'(class_id),     int'(tbl[i].e_cls));
      check($sformatf("vec%0d.margin", i),  int'(margin),       tbl[i].e_mar);
      check($sformatf("vec%0d.cnt", i),     int'(sample_cnt),   tbl[i].e_cnt);
      check($sformatf("vec%0d.timeout", i), int'(timeout_err),  int'(tbl[i].e_to));
      check($sformatf("vec%0d.overrun", i), int'(overrun),      int'(tbl[i].e_ovr));
    end

    // Timeout: lone in0, no partner.
    step(1, 0, 20, 0, 0, 0, 0);
    seen_valid = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      seen_valid |= result_valid;
    end
    check("to.before_expiry", int'(timeout_err), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("to.flag", int'(timeout_err), 1);
    check("to.no_valid", int'(seen_valid | result_valid), 0);
    idle(2);
    check("to.stays_idle", int'(result_valid), 0);

    // Partner arrives in the expiry cycle: it wins.
    step(0, 0, 0, 0, 0, 1, 0);
    check("to.clr", int'(timeout_err), 0);
    step(1, 0, 20, 0, 0, 0, 0);
    idle(TIMEOUT - 1);
    step(0, 1, 0, 30, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("race.valid", int'(result_valid), 1);
    check("race.class", int'(class_id), 1);
    check("race.margin", int'(margin), 10);
    check("race.no_timeout", int'(timeout_err), 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Backpressure: pair pulsed mid-hold is dropped.
    step(1, 1, 40, 50, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) step(1, 1, 1, 2, 0, 0, 0);
      else        step(0, 0, 0, 0, 0, 0, 0);
      check("bp.valid", int'(result_valid), 1);
      check("bp.margin", int'(margin), 10);
    end
    check("bp.overrun", int'(overrun), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("bp.dropped", int'(result_valid), 0);
    // Pair pulsed in the ack cycle is captured.
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 40, 50, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("ackcap.valid", int'(result_valid), 1);
    check("ackcap.class", int'(class_id), 0);
    check("ackcap.margin", int'(margin), 5);
    check("ackcap.overrun", int'(overrun), 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Reset in PARTIAL, then in HOLD.
    step(1, 0, 11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rstp.valid", int'(result_valid), 0);
    check("rstp.cnt", int'(sample_cnt), 0);
    step(0, 1, 0, 4, 0, 0, 0);
    idle(3);
    check("rstp.pair_gone", int'(result_valid), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, -3, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rsth.pre_valid", int'(result_valid), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rsth.valid", int'(result_valid), 0);
    check("rsth.class", int'(class_id), 0);
    check("rsth.margin", int'(margin), 0);

    // Counter wrap after 256 accepted results.
    for (int i = 0; i < 256; i++) begin
      step(1, 1, i, -i, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      if (i == 255) check("wrap.before", int'(sample_cnt), 255);
      step(0, 0, 0, 0, 1, 0, 0);
    end
    check("wrap.cnt", int'(sample_cnt), 0);

    // Randomized traffic against the reference model.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      int pct;
      pct = (i / 500) % 2 ? 8 : 30;
      step($urandom_range(99, 0) < pct, $urandom_range(99, 0) < pct,
           int'($urandom_range(131071, 0)) - 65536, int'($urandom_range(131071, 0)) - 65536,
           $urandom_range(99, 0) < 40, $urandom_range(99, 0) < 4,
           $urandom_range(999, 0) < 5);
      check_model("rand");
    end

    step(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
